inst_sequencer: RTL and testbench
=================================

Name: inst_sequencer

Overview:
- Drives the control unit's instruction and step inputs and consumes its instruction-done flag.
- Fetches 9-bit instruction words over a valid/ready stream and holds the current one in an instruction register (IR).
- For mvi, fetches the following immediate word.
- Steps the control unit through 0..MAX_STEP and returns to fetch when the control unit reports done.
- Sits between instruction memory or the input switch bus and the control unit / datapath.

Parameters:
- IW, 9: instruction and immediate width.
- MAX_STEP, 2: highest legal step index (ALU ops finish at step 2).
- OPC_MVI, 3'b001: opcode value (IR[8:6]) that requires an immediate word.

Ports:
- clock  in  1  single system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- seq_run  in  1  permits new fetches; an instruction already executing always completes.
- din  in  IW  instruction or immediate word from the source.
- din_valid  in  1  din holds a valid word.
- din_ready  out  1  sequencer accepts din this cycle.
- seq_inst  out  IW  IR contents; feeds control-unit ctrlu_inst.
- seq_step  out  2  current step; feeds control-unit ctrlu_step.
- seq_imm  out  IW  latched immediate; feeds datapath bus mux input 1.
- seq_inst_done  in  1  from control-unit ctrlu_instDone (combinational in the same cycle).
- seq_exec  out  1  high only in EXEC; the datapath ANDs it into rb_write, a_reg_write and g_reg_write.
- seq_retired  out  1  one-cycle pulse on the edge an instruction completes.
- seq_error  out  1  sticky; set when an instruction overruns MAX_STEP without done.

Behaviour:
- Reset (asynchronous, resetn=0): state=FETCH; seq_inst, seq_step and seq_imm = 0; din_ready, seq_exec, seq_retired and seq_error = 0.
- All outputs are registered, except din_ready, which is a combinational decode of the state and seq_run.
- FETCH:
  - din_ready = seq_run.
  - On din_valid & din_ready: IR←din and step←0.
  - Next state is IMM if din[8:6]==OPC_MVI, otherwise EXEC.
  - With no handshake, stay in FETCH and hold IR.
- IMM:
  - din_ready = 1, regardless of seq_run.
  - On handshake: seq_imm←din, then go to EXEC.
  - Otherwise wait indefinitely.
- EXEC:
  - din_ready = 0 and seq_exec = 1.
  - At each edge, sample seq_inst_done:
    - done=1: step←0, seq_retired pulses the next cycle, go to FETCH.
    - done=0 and step<MAX_STEP: step←step+1.
    - done=0 and step==MAX_STEP: seq_error←1, step←0, go to FETCH (instruction aborted, no retire pulse).
- Latency:
  - mv: 1 fetch cycle + 1 EXEC cycle.
  - mvi: 1 + 1 + 1.
  - ALU ops: 1 + 3.
  - Back-to-back fetch costs one cycle; there is no overlap.
- Between instructions, seq_exec=0, so a stale IR with step 0 in FETCH/IMM causes no register writes.
- Only resetn clears seq_error.
- Reset mid-operation: immediate return to FETCH; the partial instruction is discarded.
- Deasserting seq_run while in IMM or EXEC has no effect until the next FETCH.
- Words presented while din_ready=0 are ignored; the source must hold them.

Optional Feature:
- Macro: SEQ_RETIRE_CNT_EN.
- When defined:
  - Adds output seq_retire_cnt [15:0].
  - Reset value is 0.
  - Increments on each completed instruction (same edge that sets the seq_retired pulse).
  - Wraps from 0xFFFF to 0; aborted instructions are not counted.
- When undefined, the port and counter are absent and behaviour is otherwise identical.

Decomposition:
- Shared package (seq_pkg) holds:
  - opcode constants (OPC_MV=000, OPC_MVI=001, OPC_ADD..OPC_SLR=010..111);
  - the state encoding FETCH=2'd0, IMM=2'd1, EXEC=2'd2;
  - field positions: opcode [8:6], regx [5:3], regy [2:0].
- The control unit should import the same opcode constants.
- Single module; no sub-module is warranted.

Test Plan:
- mv: din=9'b000_001_010 with valid held high and seq_inst_done modelled as 1 at step 0 -> 1 FETCH cycle, 1 EXEC cycle with step=0, seq_retired pulse, din_ready high again 2 cycles after the accept.
- mvi: din=9'b001_011_000 then din=9'h0A5 -> seq_imm=0x0A5 in EXEC, seq_step=0, retire after 3 cycles total; din_ready low in EXEC.
- add with done only at step 2: din=9'b010_000_001 -> seq_step sequence 0,1,2 with seq_exec high on all three; retire pulse; next fetch on the following cycle.
- Overrun: ALU op with seq_inst_done held 0 -> after step 2, seq_error=1, no retire pulse, return to FETCH; error stays set through later good instructions.
- Stalls and halt:
  - din_valid low for 5 cycles in FETCH and in IMM -> IR and seq_imm unchanged, seq_exec=0.
  - seq_run=0 -> din_ready=0 in FETCH.
- Reset mid-EXEC: drop resetn at step 1 -> all outputs 0 immediately.
- With SEQ_RETIRE_CNT_EN defined: seq_retire_cnt=3 after three completed instructions plus one aborted instruction.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer and the control unit:
// opcodes, sequencer state encoding and instruction field positions.
package seq_pkg;

  localparam int IW_DEF       = 9;
  localparam int MAX_STEP_DEF = 2;

  localparam logic [2:0] OPC_MV  = 3'b000;
  localparam logic [2:0] OPC_MVI = 3'b001;
  localparam logic [2:0] OPC_ADD = 3'b010;
  localparam logic [2:0] OPC_SUB = 3'b011;
  localparam logic [2:0] OPC_AND = 3'b100;
  localparam logic [2:0] OPC_OR  = 3'b101;
  localparam logic [2:0] OPC_SLL = 3'b110;
  localparam logic [2:0] OPC_SLR = 3'b111;

  localparam int OPC_HI = 8;
  localparam int OPC_LO = 6;
  localparam int RX_HI  = 5;
  localparam int RX_LO  = 3;
  localparam int RY_HI  = 2;
  localparam int RY_LO  = 0;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    IMM   = 2'd1,
    EXEC  = 2'd2
  } seq_state_t;

  function automatic logic [2:0] opcode_of(input logic [8:0] word);
    return word[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/inst_sequencer.sv
// Instruction sequencer: fetches instruction (+ mvi immediate) words and steps the control unit.
// Optional retire counter output enabled by defining SEQ_RETIRE_CNT_EN.
module inst_sequencer
  import seq_pkg::seq_state_t, seq_pkg::FETCH, seq_pkg::IMM, seq_pkg::EXEC;
#(
  parameter int         IW       = 9,
  parameter int         MAX_STEP = 2,
  parameter logic [2:0] OPC_MVI  = 3'b001
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          seq_run,
  input  logic [IW-1:0] din,
  input  logic          din_valid,
  output logic          din_ready,
  output logic [IW-1:0] seq_inst,
  output logic [1:0]    seq_step,
  output logic [IW-1:0] seq_imm,
  input  logic          seq_inst_done,
  output logic          seq_exec,
  output logic          seq_retired,
  output logic          seq_error
`ifdef SEQ_RETIRE_CNT_EN
  ,
  output logic [15:0]   seq_retire_cnt
`endif
);

  localparam logic [1:0] MAX_STEP_L = MAX_STEP[1:0];

  seq_state_t state;

  // Gated by resetn so the handshake is closed while reset is held.
  always_comb begin
    din_ready = 1'b0;
    if (resetn) begin
      case (state)
        FETCH:   din_ready = seq_run;
        IMM:     din_ready = 1'b1;
        default: din_ready = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= FETCH;
      seq_inst    <= '0;
      seq_step    <= 2'd0;
      seq_imm     <= '0;
      seq_exec    <= 1'b0;
      seq_retired <= 1'b0;
      seq_error   <= 1'b0;
`ifdef SEQ_RETIRE_CNT_EN
      seq_retire_cnt <= 16'd0;
`endif
    end else begin
      seq_retired <= 1'b0;
      case (state)
        FETCH: begin
          if (din_valid && seq_run) begin
            seq_inst <= din;
            seq_step <= 2'd0;
            if (din[IW-1:IW-3] == OPC_MVI) begin
              state <= IMM;
            end else begin
              state    <= EXEC;
              seq_exec <= 1'b1;
            end
          end
        end
        IMM: begin
          if (din_valid) begin
            seq_imm  <= din;
            state    <= EXEC;
            seq_exec <= 1'b1;
          end
        end
        EXEC: begin
          if (seq_inst_done) begin
            seq_step    <= 2'd0;
            seq_retired <= 1'b1;
            seq_exec    <= 1'b0;
            state       <= FETCH;
`ifdef SEQ_RETIRE_CNT_EN
            seq_retire_cnt <= seq_retire_cnt + 16'd1;
`endif
          end else if (seq_step < MAX_STEP_L) begin
            seq_step <= seq_step + 2'd1;
          end else begin
            // Overrun: abort without retiring; error stays until reset.
            seq_error <= 1'b1;
            seq_step  <= 2'd0;
            seq_exec  <= 1'b0;
            state     <= FETCH;
          end
        end
        default: begin
          state    <= FETCH;
          seq_exec <= 1'b0;
          seq_step <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed bench for inst_sequencer with a small control-unit done model.
// Checks the retire counter too when SEQ_RETIRE_CNT_EN is defined.
module tb_inst_sequencer;

  logic       clock = 1'b0;
  logic       resetn;
  logic       seq_run;
  logic [8:0] din;
  logic       din_valid;
  logic       din_ready;
  logic [8:0] seq_inst;
  logic [1:0] seq_step;
  logic [8:0] seq_imm;
  logic       seq_inst_done;
  logic       seq_exec;
  logic       seq_retired;
  logic       seq_error;
`ifdef SEQ_RETIRE_CNT_EN
  logic [15:0] seq_retire_cnt;
`endif

  logic kill_done;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  // Control unit model: mv/mvi finish at step 0, ALU ops at step 2.
  always_comb begin
    seq_inst_done = 1'b0;
    if (!kill_done) begin
      if (seq_inst[8:6] == 3'b000 || seq_inst[8:6] == 3'b001)
        seq_inst_done = (seq_step == 2'd0);
      else
        seq_inst_done = (seq_step == 2'd2);
    end
  end

  inst_sequencer dut (
    .clock         (clock),
    .resetn        (resetn),
    .seq_run       (seq_run),
    .din           (din),
    .din_valid     (din_valid),
    .din_ready     (din_ready),
    .seq_inst      (seq_inst),
    .seq_step      (seq_step),
    .seq_imm       (seq_imm),
    .seq_inst_done (seq_inst_done),
    .seq_exec      (seq_exec),
    .seq_retired   (seq_retired),
    .seq_error     (seq_error)
`ifdef SEQ_RETIRE_CNT_EN
    ,
    .seq_retire_cnt(seq_retire_cnt)
`endif
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-16s observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    resetn    = 1'b0;
    seq_run   = 1'b0;
    din       = 9'd0;
    din_valid = 1'b0;
    kill_done = 1'b0;
    tick();
    tick();
    check("rst_inst",  16'(seq_inst), 16'h000);
    check("rst_step",  16'(seq_step), 16'h0);
    check("rst_imm",   16'(seq_imm), 16'h000);
    check("rst_ready", 16'(din_ready), 16'h0);
    check("rst_exec",  16'(seq_exec), 16'h0);
    check("rst_ret",   16'(seq_retired), 16'h0);
    check("rst_err",   16'(seq_error), 16'h0);
    resetn = 1'b1;
    tick();

    // mv r1,r2
    seq_run = 1'b1; din = 9'b000_001_010; din_valid = 1'b1;
    #1;
    check("mv_ready_f", 16'(din_ready), 16'h1);
    tick();
    din_valid = 1'b0;
    check("mv_inst",    16'(seq_inst), 16'h00A);
    check("mv_step",    16'(seq_step), 16'h0);
    check("mv_exec",    16'(seq_exec), 16'h1);
    check("mv_ready_e", 16'(din_ready), 16'h0);
    tick();
    check("mv_ret",     16'(seq_retired), 16'h1);
    check("mv_exec0",   16'(seq_exec), 16'h0);
    check("mv_ready2",  16'(din_ready), 16'h1);
    tick();
    check("mv_ret_pls", 16'(seq_retired), 16'h0);

    // FETCH stall: no valid for 5 cycles
    repeat (5) tick();
    check("fst_inst",   16'(seq_inst), 16'h00A);
    check("fst_exec",   16'(seq_exec), 16'h0);

    // mvi r3 with stall in IMM while seq_run is low
    din = 9'b001_011_000; din_valid = 1'b1;
    tick();
    din_valid = 1'b0; seq_run = 1'b0;
    check("mvi_inst",   16'(seq_inst), 16'h058);
    check("mvi_exec_i", 16'(seq_exec), 16'h0);
    repeat (5) tick();
    check("ist_inst",   16'(seq_inst), 16'h058);
    check("ist_imm",    16'(seq_imm), 16'h000);
    check("ist_exec",   16'(seq_exec), 16'h0);
    check("ist_ready",  16'(din_ready), 16'h1);
    din = 9'h0A5; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    check("mvi_imm",    16'(seq_imm), 16'h0A5);
    check("mvi_step",   16'(seq_step), 16'h0);
    check("mvi_exec",   16'(seq_exec), 16'h1);
    check("mvi_ready",  16'(din_ready), 16'h0);
    tick();
    check("mvi_ret",    16'(seq_retired), 16'h1);

    // Halted in FETCH: word ignored
    check("halt_ready", 16'(din_ready), 16'h0);
    din = 9'b010_000_001; din_valid = 1'b1;
    tick();
    tick();
    check("halt_inst",  16'(seq_inst), 16'h058);
    check("halt_exec",  16'(seq_exec), 16'h0);

    // add r0,r1 finishing at step 2
    seq_run = 1'b1;
    tick();
    din_valid = 1'b0;
    check("add_inst",   16'(seq_inst), 16'h081);
    check("add_s0",     16'(seq_step), 16'h0);
    check("add_e0",     16'(seq_exec), 16'h1);
    tick();
    check("add_s1",     16'(seq_step), 16'h1);
    check("add_e1",     16'(seq_exec), 16'h1);
    tick();
    check("add_s2",     16'(seq_step), 16'h2);
    check("add_e2",     16'(seq_exec), 16'h1);
    tick();
    check("add_ret",    16'(seq_retired), 16'h1);
    check("add_step",   16'(seq_step), 16'h0);
    check("add_ready",  16'(din_ready), 16'h1);
    check("add_err",    16'(seq_error), 16'h0);
`ifdef SEQ_RETIRE_CNT_EN
    check("cnt_3",      seq_retire_cnt, 16'd3);
`endif

    // Overrun: sub with done never reported
    kill_done = 1'b1; din = 9'b011_000_011; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    tick();
    tick();
    check("ovr_s2",     16'(seq_step), 16'h2);
    check("ovr_err0",   16'(seq_error), 16'h0);
    tick();
    check("ovr_err",    16'(seq_error), 16'h1);
    check("ovr_ret",    16'(seq_retired), 16'h0);
    check("ovr_step",   16'(seq_step), 16'h0);
    check("ovr_exec",   16'(seq_exec), 16'h0);
    check("ovr_ready",  16'(din_ready), 16'h1);
`ifdef SEQ_RETIRE_CNT_EN
    check("cnt_abort",  seq_retire_cnt, 16'd3);
`endif
    kill_done = 1'b0;

    // Good mv after overrun: error stays set
    din = 9'b000_001_010; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    tick();
    check("post_ret",   16'(seq_retired), 16'h1);
    check("post_err",   16'(seq_error), 16'h1);
`ifdef SEQ_RETIRE_CNT_EN
    check("cnt_4",      seq_retire_cnt, 16'd4);
`endif

    // Reset during EXEC step 1
    din = 9'b100_010_011; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    tick();
    check("mid_s1",     16'(seq_step), 16'h1);
    #2;
    resetn = 1'b0;
    #1;
    check("mr_inst",    16'(seq_inst), 16'h000);
    check("mr_step",    16'(seq_step), 16'h0);
    check("mr_exec",    16'(seq_exec), 16'h0);
    check("mr_err",     16'(seq_error), 16'h0);
    check("mr_ready",   16'(din_ready), 16'h0);
    check("mr_ret",     16'(seq_retired), 16'h0);
`ifdef SEQ_RETIRE_CNT_EN
    check("mr_cnt",     seq_retire_cnt, 16'd0);
`endif
    tick();
    resetn = 1'b1;
    tick();
    check("mr_fetch",   16'(din_ready), 16'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
